// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------+
// | aes_pkg : shared constants and GF(2^8) helpers for the AES-128 core   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

   localparam int NR      = 10;
   localparam int BLOCK_W = 128;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] r;
      case (round)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes ordered row 0 in the top byte.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +----------------------------------------------------------------------+
// | aes_sbox : combinational AES forward S-box (256-entry lookup)         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [0:255][7:0] c_sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_byte = c_sbox_tbl[i_byte];

endmodule

`default_nettype wire

// File: rtl/aes128_iter_core.sv
// +----------------------------------------------------------------------+
// | aes128_iter_core : iterative AES-128 encryptor, one round per clock   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module aes128_iter_core
   import aes_pkg::*;
(
   input  logic               AES_clk,
   input  logic               AES_rst_n,
   input  logic               AES_en,
   input  logic [BLOCK_W-1:0] AES_data_in,
   input  logic [BLOCK_W-1:0] AES_key_in,
   output logic [BLOCK_W-1:0] AES_data_out,
   output logic               AES_data_out_valid
);

   localparam logic [3:0] c_last_round = 4'(NR);

   logic [0:0]         r_fsm;
   logic [0:0]         w_fsm_nxt;
   logic               r_en_q;
   logic [3:0]         r_round;
   logic [BLOCK_W-1:0] r_blk;
   logic [BLOCK_W-1:0] r_rkey;

   logic               w_start;
   logic               w_step;
   logic               w_last;

   logic [BLOCK_W-1:0] w_sub;
   logic [BLOCK_W-1:0] w_shift;
   logic [BLOCK_W-1:0] w_mix;
   logic [BLOCK_W-1:0] w_next_key;
   logic [31:0]        w_rot;
   logic [31:0]        w_subword;
   logic [31:0]        w_temp;
   logic [31:0]        w_k0, w_k1, w_k2, w_k3;

   // SubBytes: byte i lives at bits [127-8i -: 8]
   for (genvar i = 0; i < 16; i++) begin : g_sub
      aes_sbox u_sbox (
         .i_byte (r_blk[BLOCK_W-1-8*i -: 8]),
         .o_byte (w_sub[BLOCK_W-1-8*i -: 8])
      );
   end

   // ShiftRows: row r rotates left by r columns
   for (genvar r = 0; r < 4; r++) begin : g_shift_row
      for (genvar c = 0; c < 4; c++) begin : g_shift_col
         assign w_shift[BLOCK_W-1-8*(r+4*c) -: 8] =
                w_sub[BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign w_mix[BLOCK_W-1-32*c -: 32] = mix_column(w_shift[BLOCK_W-1-32*c -: 32]);
   end

   // Key schedule: next round key derived from the current one on the fly
   assign w_rot = {r_rkey[23:0], r_rkey[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[31-8*i -: 8]),
         .o_byte (w_subword[31-8*i -: 8])
      );
   end

   assign w_temp     = w_subword ^ {rcon(r_round), 24'h0};
   assign w_k0       = r_rkey[127:96] ^ w_temp;
   assign w_k1       = r_rkey[95:64]  ^ w_k0;
   assign w_k2       = r_rkey[63:32]  ^ w_k1;
   assign w_k3       = r_rkey[31:0]   ^ w_k2;
   assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_fsm <= ST_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         ST_IDLE: if (w_start) w_fsm_nxt = ST_BUSY;
         ST_BUSY: if (r_round == c_last_round) w_fsm_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_start = 1'b0;
      w_step  = 1'b0;
      w_last  = 1'b0;
      case (r_fsm)
         ST_IDLE: w_start = AES_en & ~r_en_q;
         ST_BUSY: begin
            w_last = (r_round == c_last_round);
            w_step = ~w_last;
         end
      endcase
   end

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_en_q             <= 1'b0;
         r_round            <= 4'd0;
         r_blk              <= '0;
         r_rkey             <= '0;
         AES_data_out       <= '0;
         AES_data_out_valid <= 1'b0;
      end else begin
         r_en_q             <= AES_en;
         AES_data_out_valid <= w_last;
         if (w_start) begin
            r_blk   <= AES_data_in ^ AES_key_in;
            r_rkey  <= AES_key_in;
            r_round <= 4'd1;
         end else if (w_step) begin
            r_blk   <= w_mix ^ w_next_key;
            r_rkey  <= w_next_key;
            r_round <= r_round + 4'd1;
         end else if (w_last) begin
            AES_data_out <= w_shift ^ w_next_key;
            r_round      <= 4'd0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes128_iter_core.sv
// +----------------------------------------------------------------------+
// | tb_aes128_iter_core : scoreboard bench with a FIPS-197 software model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aes128_iter_core;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         en    = 1'b0;
   logic [127:0] din   = '0;
   logic [127:0] key   = '0;
   logic [127:0] dout;
   logic         valid;

   aes128_iter_core dut (
      .AES_clk            (clk),
      .AES_rst_n          (rst_n),
      .AES_en             (en),
      .AES_data_in        (din),
      .AES_key_in         (key),
      .AES_data_out       (dout),
      .AES_data_out_valid (valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] ct;
      int           due;
   } exp_t;

   exp_t         q[$];
   int           cyc      = 0;
   int           n_vec    = 0;
   int           n_err    = 0;
   logic [127:0] exp_hold = '0;
   logic [7:0]   sb [256];

   always @(posedge clk) cyc++;

   // ---------------- reference model (FIPS-197 from first principles) ----
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
         for (int i = 0; i < 16; i++) s[i] = t[i];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("reset_data_out", dout, 128'h0);
         chk("reset_valid", {127'h0, valid}, 128'h0);
      end else if (valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("ciphertext", dout, e.ct);
            chk("latency_cycle", 128'(cyc), 128'(e.due));
            exp_hold = e.ct;
         end
      end else begin
         chk("data_out_hold", dout, exp_hold);
         if (q.size() > 0 && cyc > q[0].due) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_valid: got no valid by cycle %0d expected at cycle %0d", cyc, q[0].due);
            void'(q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [127:0] ct);
      exp_t e;
      e.ct  = ct;
      e.due = cyc + 11;
      q.push_back(e);
   endtask

   task automatic issue(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
      din = pt;
      key = k;
      en  = 1'b1;
      push_exp(ct);
      tick();
      en  = 1'b0;
      din = rand128();
      key = rand128();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      q.delete();
      exp_hold = '0;
      repeat (cycles) tick();
   endtask

   initial begin
      logic [127:0] pt, k;
      build_sbox();
      #1;
      do_reset(3);
      rst_n = 1'b1;
      tick();

      // Known-answer vectors, issued exactly 11 cycles apart
      issue(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      repeat (10) tick();
      issue(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'h3925841d02dc09fbdc118597196a0b32);
      repeat (10) tick();
      issue(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      repeat (12) tick();

      // A second edge while busy must be dropped
      pt = rand128(); k = rand128();
      issue(pt, k, ref_encrypt(k, pt));
      repeat (4) tick();
      din = rand128(); key = rand128(); en = 1'b1;
      tick();
      en = 1'b0;
      repeat (7) tick();

      // AES_en held high for 51 cycles: one result only
      pt = rand128(); k = rand128();
      din = pt; key = k; en = 1'b1;
      push_exp(ref_encrypt(k, pt));
      tick();
      repeat (19) tick();
      din = rand128();
      repeat (31) tick();
      en = 1'b0;
      din = rand128(); key = rand128();
      repeat (5) tick();

      // Reset in the middle of an operation, then a fresh start
      pt = rand128(); k = rand128();
      issue(pt, k, ref_encrypt(k, pt));
      repeat (5) tick();
      do_reset(2);
      rst_n = 1'b1;
      tick();
      pt = rand128(); k = rand128();
      issue(pt, k, ref_encrypt(k, pt));
      repeat (11) tick();

      // Randomised blocks with random idle gaps
      for (int n = 0; n < 20; n++) begin
         pt = rand128(); k = rand128();
         issue(pt, k, ref_encrypt(k, pt));
         repeat (10 + $urandom_range(0, 3)) tick();
      end

      // AES_en already high when reset releases counts as an edge
      pt = rand128(); k = rand128();
      din = pt; key = k; en = 1'b1;
      do_reset(2);
      rst_n = 1'b1;
      push_exp(ref_encrypt(k, pt));
      tick();
      en = 1'b0;
      din = rand128(); key = rand128();

      for (int i = 0; i < 50 && q.size() > 0; i++) tick();
      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d results outstanding expected 0", q.size());
      end
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
